serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor. Computes diff = a - b - bin, LSB first, one bit per clock through a single full-subtractor cell and a borrow register.
- Reuses the arithmetic library's full-adder-style cell logic in the subtract direction.
- Serves as a small-area subtract/compare unit for sequential datapaths where a parallel ripple subtractor is too large.
- Uses a start/busy/done handshake.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request side; the slave returns status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor step per clock.
// Results are held until the next completion or reset.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-2:0]   r_sd;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic               r_bout;
    logic               r_ovf;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res;

    always_comb begin
        w_accept  = bus.start && (r_state != StRun);
        w_last    = (r_state == StRun) && (r_cnt == CNT_W'(WIDTH - 1));
        w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
        w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
        // Previously produced bits sit in r_sd; the current bit enters at the MSB.
        w_res     = {w_d, r_sd};
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = bus.start ? StRun : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sd    <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= bus.bin;
            r_cnt   <= '0;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (r_state == StRun) begin
            r_sa <= r_sa >> 1;
            r_sb <= r_sb >> 1;
            r_br <= w_br_next;
            r_sd <= w_res[WIDTH-1:1];
            if (w_last) begin
                r_diff <= w_res;
                r_bout <= w_br_next;
                r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.busy     = (r_state == StRun);
    assign bus.done     = (r_state == StDone);
    assign bus.diff     = r_diff;
    assign bus.bout     = r_bout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=13: directed vectors plus random traffic,
// checked every cycle against an arithmetic model of a - b - bin with edge-indexed timing.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst8;
    logic rst13;
    bit   done13 = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(13)) if13 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8));
    serial_subtractor #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst13), .bus(if13));

    // Model state, index 0 = WIDTH 8, index 1 = WIDTH 13.
    bit     m_armed [2];
    bit     m_run   [2];
    bit     m_done  [2];
    bit     m_bout  [2];
    bit     m_ovf   [2];
    longint m_diff  [2];
    longint m_acc   [2];
    longint m_edge  [2];
    bit     p_bout  [2];
    bit     p_ovf   [2];
    longint p_diff  [2];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_sub(input int w, input longint a, input longint b,
                                    input longint bi, output longint d, output bit bo,
                                    output bit ov);
        longint m  = longint'(1) << w;
        longint h  = m / 2;
        longint r  = a - b - bi;
        longint sa = (a >= h) ? a - m : a;
        longint sb = (b >= h) ? b - m : b;
        longint sr = sa - sb - bi;
        bo = (r < 0);
        d  = ((r % m) + m) % m;
        ov = (sr < -h) || (sr > h - 1);
    endfunction

    task automatic model_step(input int id, input int w, input bit r, input bit s,
                              input longint a, input longint b, input bit bi);
        if (r) begin
            m_armed[id] = 1'b1;
            m_run[id]   = 1'b0;
            m_done[id]  = 1'b0;
            m_diff[id]  = 0;
            m_bout[id]  = 1'b0;
            m_ovf[id]   = 1'b0;
        end else if (m_run[id]) begin
            m_done[id] = (m_edge[id] == m_acc[id] + w);
            if (m_done[id]) begin
                m_run[id]  = 1'b0;
                m_diff[id] = p_diff[id];
                m_bout[id] = p_bout[id];
                m_ovf[id]  = p_ovf[id];
            end
        end else begin
            m_done[id] = 1'b0;
            if (s) begin
                m_run[id] = 1'b1;
                m_acc[id] = m_edge[id];
                ref_sub(w, a, b, longint'(bi), p_diff[id], p_bout[id], p_ovf[id]);
            end
        end
        m_edge[id]++;
    endtask

    task automatic check_out(input int id, input bit busy, input bit done, input longint diff,
                             input bit bo, input bit ov);
        if (m_armed[id]) begin
            chk($sformatf("busy%0d", id), longint'(busy), longint'(m_run[id]));
            chk($sformatf("done%0d", id), longint'(done), longint'(m_done[id]));
            chk($sformatf("diff%0d", id), diff, m_diff[id]);
            chk($sformatf("bout%0d", id), longint'(bo), longint'(m_bout[id]));
            chk($sformatf("ovf%0d", id), longint'(ov), longint'(m_ovf[id]));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_armed[i] = 0; m_run[i] = 0; m_done[i] = 0; m_bout[i] = 0; m_ovf[i] = 0;
            m_diff[i] = 0; m_acc[i] = 0; m_edge[i] = 0;
        end
        forever begin
            @(posedge clk);
            model_step(0, 8, rst8, if8.start, longint'(if8.a), longint'(if8.b), if8.bin);
            model_step(1, 13, rst13, if13.start, longint'(if13.a), longint'(if13.b), if13.bin);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            check_out(0, if8.busy, if8.done, longint'(if8.diff), if8.bout, if8.overflow);
            check_out(1, if13.busy, if13.done, longint'(if13.diff), if13.bout, if13.overflow);
        end
    end

    task automatic wait_done8(input string nm, output int cyc);
        cyc = 0;
        while (!if8.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!if8.done) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit bi,
                       input logic [7:0] ed, input bit eb, input bit eo, input string nm);
        int cyc;
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bi;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        // Operand changes during the run must not disturb the result.
        if8.a     = ~a;
        if8.b     = ~b;
        if8.bin   = ~bi;
        wait_done8(nm, cyc);
        chk({nm, "_lat"}, cyc, 8);
        chk({nm, "_diff"}, longint'(if8.diff), longint'(ed));
        chk({nm, "_bout"}, longint'(if8.bout), longint'(eb));
        chk({nm, "_ovf"}, longint'(if8.overflow), longint'(eo));
        @(negedge clk);
    endtask

    initial begin
        rst13      = 1'b1;
        if13.start = 1'b0;
        if13.a     = '0;
        if13.b     = '0;
        if13.bin   = 1'b0;
        repeat (2) @(negedge clk);
        rst13 = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            rst13      = ($urandom_range(0, 299) == 0);
            if13.start = ($urandom_range(0, 3) != 0);
            if13.a     = 13'($urandom);
            if13.b     = 13'($urandom);
            if13.bin   = 1'($urandom);
            @(negedge clk);
        end
        if13.start = 1'b0;
        done13     = 1'b1;
    end

    initial begin
        longint d;
        bit     bo;
        bit     ov;
        int     cyc;
        int     seen;

        ref_sub(8, 'h80, 'h01, 0, d, bo, ov);
        chk("model8_d", d, 'h7F); chk("model8_bo", longint'(bo), 0); chk("model8_ov", longint'(ov), 1);
        ref_sub(13, 'h0FFF, 'h1FFF, 0, d, bo, ov);
        chk("model13_d", d, 'h1000); chk("model13_bo", longint'(bo), 1);
        chk("model13_ov", longint'(ov), 1);

        rst8      = 1'b1;
        if8.start = 1'b0;
        if8.a     = '0;
        if8.b     = '0;
        if8.bin   = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        chk("rst_busy", longint'(if8.busy), 0);
        chk("rst_done", longint'(if8.done), 0);
        chk("rst_diff", longint'(if8.diff), 0);
        chk("rst_bout", longint'(if8.bout), 0);
        chk("rst_ovf", longint'(if8.overflow), 0);

        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "op5a3c");
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "op0001");
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "op8001");
        op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "op100f");
        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "op0000b");

        // A second request during the run is ignored.
        if8.a = 8'h5A; if8.b = 8'h3C; if8.bin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
        if8.a = 8'hFF; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8("ignore", cyc);
        chk("ignore_lat", cyc, 5);
        chk("ignore_diff", longint'(if8.diff), 'h1E);
        @(negedge clk);
        chk("ignore_idle", longint'(if8.busy), 0);

        // Start held high: each DONE cycle accepts the next request.
        if8.a = 8'h05; if8.b = 8'h02; if8.bin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        wait_done8("b2b1", cyc);
        chk("b2b1_lat", cyc, 8);
        chk("b2b1_diff", longint'(if8.diff), 'h03);
        @(negedge clk);
        wait_done8("b2b2", cyc);
        chk("b2b_gap", cyc, 8);
        chk("b2b2_diff", longint'(if8.diff), 'h03);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-run aborts and clears the held result.
        if8.a = 8'h5A; if8.b = 8'h3C; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("abort_busy", longint'(if8.busy), 0);
        chk("abort_done", longint'(if8.done), 0);
        chk("abort_diff", longint'(if8.diff), 0);
        chk("abort_bout", longint'(if8.bout), 0);
        chk("abort_ovf", longint'(if8.overflow), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) seen++;
        end
        chk("abort_nodone", seen, 0);
        op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, "post_abort");

        for (int i = 0; i < 18000; i++) begin
            rst8      = ($urandom_range(0, 299) == 0);
            if8.start = ($urandom_range(0, 3) != 0);
            if8.a     = 8'($urandom);
            if8.b     = 8'($urandom);
            if8.bin   = 1'($urandom);
            @(negedge clk);
        end
        rst8      = 1'b0;
        if8.start = 1'b0;

        for (int i = 0; i < 40000 && !done13; i++) @(negedge clk);
        if (!done13) chk("w13_timeout", 0, 1);
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
